// File: rtl/draw_scheduler.sv
// Frame-level sequencer for the shared entity draw engine: snapshots the entity
// table on frame_tick, erases the previous positions, then draws the new ones.
// Optional macro DRAW_SCHED_SKIP_STATIC_EN skips slots that did not change.
module draw_scheduler #(
  parameter int ENTITY_SIZE  = 34,
  parameter int NUM_ENTITIES = 8,
  localparam int IW = (NUM_ENTITIES > 1) ? $clog2(NUM_ENTITIES) : 1
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                frame_tick,
  input  logic [NUM_ENTITIES*ENTITY_SIZE-1:0] entities,
  output logic                                busy,
  output logic                                frame_done,
  output logic                                eng_start,
  output logic                                eng_erase,
  output logic [9:0]                          eng_x,
  output logic [9:0]                          eng_y,
  output logic [5:0]                          eng_dir,
  output logic [IW-1:0]                       eng_slot,
  input  logic                                eng_done
);

  localparam int TW      = NUM_ENTITIES * ENTITY_SIZE;
  localparam int DW      = ENTITY_SIZE - 1;
  localparam int X_LSB   = 6;
  localparam int Y_LSB   = 16;
  localparam int DIR_LSB = 0;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ENTITIES - 1);

  typedef enum logic [2:0] {
    IDLE,
    E_SCAN,
    E_WAIT,
    D_SCAN,
    D_WAIT,
    FINISH
  } state_t;

  state_t                   state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic                     pending_q, pending_d;
  logic [NUM_ENTITIES-1:0]  prev_valid_q, prev_valid_d;
  logic [NUM_ENTITIES*DW-1:0] prev_data_q, prev_data_d;
  logic [TW-1:0]            snap_q, snap_d;
  logic                     busy_q, busy_d;
  logic                     frame_done_q, frame_done_d;
  logic                     eng_start_q, eng_start_d;
  logic                     eng_erase_q, eng_erase_d;
  logic [9:0]               eng_x_q, eng_x_d;
  logic [9:0]               eng_y_q, eng_y_d;
  logic [5:0]               eng_dir_q, eng_dir_d;
  logic [IW-1:0]            eng_slot_q, eng_slot_d;

  int         base_s, base_p;
  logic       prev_valid, snap_valid, unchanged, last_slot, done_seen, use_prev;
  logic [9:0] job_x, job_y;
  logic [5:0] job_dir;

  // Current-slot view of both tables; the erase pass reads prev, the draw pass snap.
  always_comb begin
    base_s     = int'(idx_q) * ENTITY_SIZE;
    base_p     = int'(idx_q) * DW;
    prev_valid = prev_valid_q[idx_q];
    snap_valid = snap_q[base_s + ENTITY_SIZE - 1];
`ifdef DRAW_SCHED_SKIP_STATIC_EN
    unchanged  = (prev_valid == snap_valid) &&
                 (prev_data_q[base_p +: DW] == snap_q[base_s +: DW]);
`else
    unchanged  = 1'b0;
`endif
    last_slot  = (idx_q == LAST_IDX);
    // The done pulse is only trusted once the start pulse has been seen by the engine.
    done_seen  = eng_done && !eng_start_q;
    use_prev   = (state_q == E_SCAN);
    job_x      = use_prev ? prev_data_q[base_p + X_LSB +: 10]  : snap_q[base_s + X_LSB +: 10];
    job_y      = use_prev ? prev_data_q[base_p + Y_LSB +: 10]  : snap_q[base_s + Y_LSB +: 10];
    job_dir    = use_prev ? prev_data_q[base_p + DIR_LSB +: 6] : snap_q[base_s + DIR_LSB +: 6];
  end

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    state_d      = state_q;
    idx_d        = idx_q;
    pending_d    = pending_q;
    prev_valid_d = prev_valid_q;
    prev_data_d  = prev_data_q;
    snap_d       = snap_q;
    busy_d       = (state_q != IDLE);
    frame_done_d = 1'b0;
    eng_start_d  = 1'b0;
    eng_erase_d  = eng_erase_q;
    eng_x_d      = eng_x_q;
    eng_y_d      = eng_y_q;
    eng_dir_d    = eng_dir_q;
    eng_slot_d   = eng_slot_q;

    if (frame_tick && (state_q != IDLE) && (state_q != FINISH)) begin
      pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          snap_d  = entities;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = E_SCAN;
        end
      end
      E_SCAN, D_SCAN: begin
        if ((use_prev ? prev_valid : snap_valid) && !unchanged) begin
          eng_start_d = 1'b1;
          eng_erase_d = use_prev;
          eng_x_d     = job_x;
          eng_y_d     = job_y;
          eng_dir_d   = job_dir;
          eng_slot_d  = idx_q;
          state_d     = use_prev ? E_WAIT : D_WAIT;
        end else if (last_slot) begin
          idx_d   = '0;
          state_d = use_prev ? D_SCAN : FINISH;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      E_WAIT, D_WAIT: begin
        if (done_seen) begin
          if (last_slot) begin
            idx_d   = '0;
            state_d = (state_q == E_WAIT) ? D_SCAN : FINISH;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = (state_q == E_WAIT) ? E_SCAN : D_SCAN;
          end
        end
      end
      FINISH: begin
        for (int i = 0; i < NUM_ENTITIES; i++) begin
          prev_valid_d[i]            = snap_q[i*ENTITY_SIZE + ENTITY_SIZE - 1];
          prev_data_d[i*DW +: DW]    = snap_q[i*ENTITY_SIZE +: DW];
        end
        frame_done_d = 1'b1;
        pending_d    = 1'b0;
        idx_d        = '0;
        // A queued tick (or one landing right now) restarts without an IDLE cycle.
        if (pending_q || frame_tick) begin
          snap_d  = entities;
          state_d = E_SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      prev_valid_q <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      eng_start_q  <= 1'b0;
      eng_erase_q  <= 1'b0;
      eng_x_q      <= '0;
      eng_y_q      <= '0;
      eng_dir_q    <= '0;
      eng_slot_q   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      prev_valid_q <= prev_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      eng_start_q  <= eng_start_d;
      eng_erase_q  <= eng_erase_d;
      eng_x_q      <= eng_x_d;
      eng_y_q      <= eng_y_d;
      eng_dir_q    <= eng_dir_d;
      eng_slot_q   <= eng_slot_d;
    end
  end

  // NOTE: table payloads are not reset; only the prev valid bits need a known value.
  always_ff @(posedge clk) begin
    snap_q      <= snap_d;
    prev_data_q <= prev_data_d;
  end

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign eng_start  = eng_start_q;
  assign eng_erase  = eng_erase_q;
  assign eng_x      = eng_x_q;
  assign eng_y      = eng_y_q;
  assign eng_dir    = eng_dir_q;
  assign eng_slot   = eng_slot_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Self-checking bench for draw_scheduler: randomized entity tables and engine
// latencies compared against a per-frame job-list model of the erase/draw passes.
module tb_draw_scheduler;

  localparam int ES      = 34;
  localparam int NE      = 8;
  localparam int IW      = 3;
  localparam int TIMEOUT = 3000;
`ifdef DRAW_SCHED_SKIP_STATIC_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset_n;
  logic           frame_tick;
  logic [NE*ES-1:0] entities;
  logic           eng_done;
  logic           busy, frame_done, eng_start, eng_erase;
  logic [9:0]     eng_x, eng_y;
  logic [5:0]     eng_dir;
  logic [IW-1:0]  eng_slot;

  typedef logic [ES-1:0] rec_t;
  typedef struct {
    int            cyc;
    logic          erase;
    logic [9:0]    x;
    logic [9:0]    y;
    logic [5:0]    dir;
    logic [IW-1:0] slot;
  } job_t;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   eng_lat = 3;
  int   busy_low = 0;
  int   last_t0 = 0;
  int   exp_cost = 0;
  job_t got[$];
  job_t exp_q[$];
  int   fd_cyc[$];
  int   done_cyc[$];
  rec_t tbl [NE];
  rec_t mprev [NE];

  draw_scheduler dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .frame_tick(frame_tick),
    .entities  (entities),
    .busy      (busy),
    .frame_done(frame_done),
    .eng_start (eng_start),
    .eng_erase (eng_erase),
    .eng_x     (eng_x),
    .eng_y     (eng_y),
    .eng_dir   (eng_dir),
    .eng_slot  (eng_slot),
    .eng_done  (eng_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log every job start, frame_done pulse and idle-busy cycle.
  initial begin : monitor
    job_t j;
    forever begin
      @(negedge clk);
      if (eng_start === 1'b1) begin
        j.cyc = cyc; j.erase = eng_erase; j.x = eng_x; j.y = eng_y;
        j.dir = eng_dir; j.slot = eng_slot;
        got.push_back(j);
      end
      if (frame_done === 1'b1) fd_cyc.push_back(cyc);
      if (busy !== 1'b1) busy_low++;
    end
  end

  // Engine model: done pulse eng_lat cycles after a start.
  initial begin : engine
    eng_done = 1'b0;
    forever begin
      @(negedge clk);
      if (eng_start === 1'b1 && reset_n === 1'b1) begin
        repeat (eng_lat - 1) @(negedge clk);
        eng_done = 1'b1;
        done_cyc.push_back(cyc);
        @(negedge clk);
        eng_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic rec_t mk_rec(bit v, int x, int y, int d);
    rec_t r;
    r = '0;
    r[ES-1]  = v;
    r[25:16] = y[9:0];
    r[15:6]  = x[9:0];
    r[5:0]   = d[5:0];
    return r;
  endfunction

  function automatic rec_t rand_rec(bit v);
    return mk_rec(v, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                  int'($urandom_range(0, 63)));
  endfunction

  function automatic bit unchanged(rec_t p, rec_t s);
    return SKIP_EN && (p == s);
  endfunction

  function automatic job_t mk_job(bit erase, int slot, rec_t r);
    job_t j;
    j.cyc = 0; j.erase = erase; j.x = r[15:6]; j.y = r[25:16];
    j.dir = r[5:0]; j.slot = slot[IW-1:0];
    return j;
  endfunction

  // Reference: erase jobs for valid old slots, then draw jobs for valid new slots;
  // each issued job costs eng_lat+1 cycles, each skipped slot 1 cycle.
  task automatic model_frame();
    exp_q.delete();
    exp_cost = 0;
    for (int i = 0; i < NE; i++) begin
      if (mprev[i][ES-1] && !unchanged(mprev[i], tbl[i])) begin
        exp_q.push_back(mk_job(1'b1, i, mprev[i]));
        exp_cost += eng_lat + 1;
      end else exp_cost += 1;
    end
    for (int i = 0; i < NE; i++) begin
      if (tbl[i][ES-1] && !unchanged(mprev[i], tbl[i])) begin
        exp_q.push_back(mk_job(1'b0, i, tbl[i]));
        exp_cost += eng_lat + 1;
      end else exp_cost += 1;
    end
  endtask

  task automatic drive_table();
    for (int i = 0; i < NE; i++) entities[i*ES +: ES] = tbl[i];
  endtask

  task automatic scramble_table();
    logic [63:0] r;
    for (int i = 0; i < NE; i++) begin
      r = {$urandom(), $urandom()};
      entities[i*ES +: ES] = r[ES-1:0];
    end
  endtask

  task automatic clear_logs();
    got.delete();
    fd_cyc.delete();
    done_cyc.delete();
  endtask

  task automatic pulse_tick(output int t);
    @(posedge clk);
    #1 frame_tick = 1'b1;
    t = cyc;
    @(posedge clk);
    #1 frame_tick = 1'b0;
  endtask

  task automatic run_frame(input string name, input bit scramble);
    int t0;
    int n;
    model_frame();
    clear_logs();
    drive_table();
    pulse_tick(t0);
    last_t0 = t0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL %s_busy_on got %b want 1", name, busy);
    end
    if (scramble) scramble_table();
    n = 0;
    while (fd_cyc.size() == 0 && n < TIMEOUT) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (fd_cyc.size() == 0) begin
      errors++; $display("FAIL %s_timeout got no frame_done want frame_done", name);
      return;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL %s_busy_off got %b want 0", name, busy);
    end
    checks++;
    if (fd_cyc.size() != 1) begin
      errors++; $display("FAIL %s_done_pulses got %0d want 1", name, fd_cyc.size());
    end
    checks++;
    if (fd_cyc[0] - t0 != exp_cost + 2) begin
      errors++; $display("FAIL %s_duration got %0d want %0d", name, fd_cyc[0] - t0, exp_cost + 2);
    end
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++; $display("FAIL %s_job_count got %0d want %0d", name, got.size(), exp_q.size());
    end
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got[k].erase !== exp_q[k].erase || got[k].x !== exp_q[k].x || got[k].y !== exp_q[k].y ||
          got[k].dir !== exp_q[k].dir || got[k].slot !== exp_q[k].slot) begin
        errors++;
        $display("FAIL %s_job%0d got e=%b x=%0d y=%0d d=%0d s=%0d want e=%b x=%0d y=%0d d=%0d s=%0d",
                 name, k, got[k].erase, got[k].x, got[k].y, got[k].dir, got[k].slot,
                 exp_q[k].erase, exp_q[k].x, exp_q[k].y, exp_q[k].dir, exp_q[k].slot);
      end
    end
    for (int k = 1; k < got.size() && k - 1 < done_cyc.size(); k++) begin
      checks++;
      if (got[k].cyc - done_cyc[k-1] < 2) begin
        errors++; $display("FAIL %s_gap%0d got %0d want >=2", name, k, got[k].cyc - done_cyc[k-1]);
      end
    end
    mprev = tbl;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; frame_tick = 1'b0; entities = '0;
    for (int i = 0; i < NE; i++) begin tbl[i] = '0; mprev[i] = '0; end
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, frame_done, eng_start, eng_erase} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {busy, frame_done, eng_start, eng_erase});
    end
    checks++;
    if ({eng_x, eng_y, eng_dir, eng_slot} !== '0) begin
      errors++; $display("FAIL reset_fields got x=%0d y=%0d d=%0d s=%0d want 0", eng_x, eng_y, eng_dir, eng_slot);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle_busy got %b want 0", busy);
    end
  endtask

  task automatic test_single();
    eng_lat = 3;
    for (int i = 0; i < NE; i++) tbl[i] = '0;
    tbl[0] = mk_rec(1'b1, 50, 20, 1);
    run_frame("single", 1'b0);
    checks++;
    if (got.size() != 1 || got[0].erase !== 1'b0 || got[0].x !== 10'd50 || got[0].y !== 10'd20 ||
        got[0].dir !== 6'd1 || got[0].slot !== 3'd0) begin
      errors++; $display("FAIL single_job got count=%0d want one draw job x=50 y=20 dir=1 slot=0", got.size());
    end
  endtask

  task automatic test_move();
    eng_lat = 2;
    tbl[0] = mk_rec(1'b1, 51, 20, 1);
    run_frame("move", 1'b1);
    checks++;
    if (got.size() != 2 || got[0].erase !== 1'b1 || got[0].x !== 10'd50 ||
        got[1].erase !== 1'b0 || got[1].x !== 10'd51) begin
      errors++; $display("FAIL move_order got count=%0d want erase x=50 then draw x=51", got.size());
    end
    checks++;
    if (got.size() == 0 || got[0].cyc - last_t0 != 2) begin
      errors++; $display("FAIL move_latency got %0d want 2", (got.size() == 0) ? -1 : got[0].cyc - last_t0);
    end
  endtask

  task automatic test_multi();
    eng_lat = 5;
    for (int i = 0; i < NE; i++) tbl[i] = '0;
    tbl[0] = rand_rec(1'b1); tbl[3] = rand_rec(1'b1); tbl[7] = rand_rec(1'b1);
    run_frame("multi_a", 1'b1);
    for (int i = 0; i < NE; i++) if (tbl[i][ES-1]) tbl[i][15:6] = tbl[i][15:6] + 10'd1;
    run_frame("multi_b", 1'b1);
    checks++;
    if (got.size() != 6 || got[0].slot !== 3'd0 || got[1].slot !== 3'd3 || got[2].slot !== 3'd7 ||
        got[3].slot !== 3'd0 || got[4].slot !== 3'd3 || got[5].slot !== 3'd7) begin
      errors++; $display("FAIL multi_slots got count=%0d want slots 0,3,7,0,3,7", got.size());
    end
  endtask

  task automatic test_min_frame();
    eng_lat = 2;
    for (int i = 0; i < NE; i++) tbl[i] = '0;
    run_frame("min_a", 1'b0);
    run_frame("min_b", 1'b1);
    checks++;
    if (fd_cyc.size() == 0 || fd_cyc[0] - last_t0 != 2*NE + 2 || got.size() != 0) begin
      errors++; $display("FAIL min_frame got starts=%0d want 0 and %0d cycles", got.size(), 2*NE + 2);
    end
  endtask

  task automatic test_static();
    eng_lat = 2;
    for (int i = 0; i < NE; i++) tbl[i] = rand_rec(1'b1);
    run_frame("static_a", 1'b0);
    run_frame("static_b", 1'b0);
`ifdef DRAW_SCHED_SKIP_STATIC_EN
    checks++;
    if (got.size() != 0 || fd_cyc.size() == 0 || fd_cyc[0] - last_t0 != 2*NE + 2) begin
      errors++; $display("FAIL static_skip got starts=%0d want 0 and %0d cycles", got.size(), 2*NE + 2);
    end
`endif
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      eng_lat = int'($urandom_range(2, 6));
      for (int i = 0; i < NE; i++) if ($urandom_range(0, 2) != 0) tbl[i] = rand_rec(1'($urandom_range(0, 1)));
      run_frame("random", 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    rec_t t1 [NE];
    rec_t t2 [NE];
    rec_t mp0 [NE];
    job_t all_q[$];
    int   c1, c2, t0, n, bl;
    eng_lat = 3;
    for (int i = 0; i < NE; i++) begin
      t1[i] = rand_rec(1'($urandom_range(0, 1)));
      t2[i] = rand_rec(1'($urandom_range(0, 1)));
    end
    mp0 = mprev;
    tbl = t1; model_frame(); all_q = exp_q; c1 = exp_cost;
    mprev = t1; tbl = t2; model_frame(); c2 = exp_cost;
    foreach (exp_q[k]) all_q.push_back(exp_q[k]);
    mprev = mp0; tbl = t1;
    clear_logs();
    drive_table();
    pulse_tick(t0);
    tbl = t2;
    drive_table();
    @(negedge clk);
    #1 busy_low = 0;
    repeat (3) begin
      @(posedge clk); #1 frame_tick = 1'b1;
      @(posedge clk); #1 frame_tick = 1'b0;
    end
    n = 0;
    while (fd_cyc.size() < 2 && n < TIMEOUT) begin
      @(posedge clk);
      n++;
    end
    bl = busy_low;
    checks++;
    if (bl != 0) begin
      errors++; $display("FAIL b2b_busy_gap got %0d low cycles want 0", bl);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (fd_cyc.size() != 2) begin
      errors++; $display("FAIL b2b_frames got %0d want 2", fd_cyc.size());
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL b2b_busy_end got %b want 0", busy);
    end
    if (fd_cyc.size() >= 2) begin
      checks++;
      if (fd_cyc[0] - t0 != c1 + 2 || fd_cyc[1] - fd_cyc[0] != c2 + 1) begin
        errors++; $display("FAIL b2b_timing got %0d,%0d want %0d,%0d",
                           fd_cyc[0] - t0, fd_cyc[1] - fd_cyc[0], c1 + 2, c2 + 1);
      end
    end
    checks++;
    if (got.size() != all_q.size()) begin
      errors++; $display("FAIL b2b_job_count got %0d want %0d", got.size(), all_q.size());
    end
    for (int k = 0; k < got.size() && k < all_q.size(); k++) begin
      checks++;
      if (got[k].erase !== all_q[k].erase || got[k].x !== all_q[k].x || got[k].y !== all_q[k].y ||
          got[k].dir !== all_q[k].dir || got[k].slot !== all_q[k].slot) begin
        errors++; $display("FAIL b2b_job%0d got s=%0d e=%b want s=%0d e=%b",
                           k, got[k].slot, got[k].erase, all_q[k].slot, all_q[k].erase);
      end
    end
    mprev = t2;
  endtask

  task automatic test_reset_mid_frame();
    int  t0, n;
    bit  found;
    eng_lat = 5;
    for (int i = 0; i < NE; i++) tbl[i] = rand_rec(1'($urandom_range(0, 1)));
    tbl[1] = rand_rec(1'b1);
    clear_logs();
    drive_table();
    pulse_tick(t0);
    found = 1'b0;
    n = 0;
    while (!found && n < TIMEOUT) begin
      @(negedge clk);
      #1;
      foreach (got[k]) if (got[k].erase === 1'b0) found = 1'b1;
      n++;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL midreset_wait got no draw job want draw job");
    end
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, frame_done, eng_start, eng_erase, eng_x, eng_y, eng_dir, eng_slot} !== '0) begin
      errors++; $display("FAIL midreset_outputs got busy=%b start=%b x=%0d y=%0d want all 0",
                         busy, eng_start, eng_x, eng_y);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    for (int i = 0; i < NE; i++) begin
      mprev[i] = '0;
      tbl[i] = rand_rec(1'($urandom_range(0, 1)));
    end
    tbl[2] = rand_rec(1'b1);
    run_frame("post_reset", 1'b1);
    checks++;
    n = 0;
    foreach (got[k]) if (got[k].erase !== 1'b0) n++;
    if (n != 0 || got.size() == 0) begin
      errors++; $display("FAIL post_reset_erases got %0d erases of %0d jobs want 0 erases", n, got.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_move();
    test_multi();
    test_min_frame();
    test_static();
    test_random();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
